// File: rtl/seq_shift4_unit.sv
// seq_shift4_unit -- multi-cycle shift unit for the integer ALU.
//
// Latches one operand with an op and a shift amount, then applies a single-bit
// shift step per clock until the amount is used up. The final value is
// published on y together with a one-cycle done pulse.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; accepted in IDLE or DONE, ignored in SHIFT
//   op     in   2      00 LSL, 01 LSR, 10 ASR, 11 ROR
//   a      in   WIDTH  operand, latched with start
//   shamt  in   SHW    shift amount, latched with start
//   busy   out  1      high while shift steps are in progress
//   done   out  1      one-cycle pulse: y valid and final
//   y      out  WIDTH  result register; changes only when an operation completes
module seq_shift4_unit #(
  parameter int WIDTH = 4,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             busy_q, done_q;

  // One single-bit step. Amounts >= WIDTH need no special handling: repeated
  // steps drain to zero (LSL/LSR), saturate to the sign (ASR) or wrap (ROR).
  function automatic logic [WIDTH-1:0] shift_step(input logic [1:0]       o,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    case (o)
      OP_LSL:  r = {d[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {1'b0, d[WIDTH-1:1]};
      OP_ASR:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROR:  r = {d[0], d[WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    count_d = count_q;
    y_d     = y_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          data_d  = a;
          op_d    = op;
          count_d = shamt;
          if (shamt == '0) begin
            state_d = S_DONE;
            y_d     = a;
          end else begin
            state_d = S_SHIFT;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        data_d  = shift_step(op_q, data_q);
        count_d = count_q - SHW'(1);
        // count_q == 1 means this edge performs the last step.
        if (count_q == SHW'(1)) begin
          state_d = S_DONE;
          y_d     = data_d;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      op_q    <= '0;
      count_q <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      count_q <= count_d;
      y_q     <= y_d;
      // Flags are registered from the next state so they align with it
      // and never glitch.
      busy_q  <= (state_d == S_SHIFT);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

endmodule

// File: tb/tb_seq_shift4_unit.sv
// Self-checking bench for seq_shift4_unit: directed cases followed by random
// operations, compared against an arithmetic reference model.
module tb_seq_shift4_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [3:0] a;
  logic [2:0] shamt;
  logic       busy, done;
  logic [3:0] y;

  int passed = 0;
  int total  = 0;

  seq_shift4_unit #(.WIDTH(4), .SHW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: whole shift by n computed directly with integer arithmetic.
  function automatic logic [3:0] model(input logic [1:0] o, input logic [3:0] v, input int n);
    int r, sv, rr;
    case (o)
      2'b00: r = (int'(v) << n) & 15;
      2'b01: r = int'(v) >> n;
      2'b10: begin
        sv = (v >= 4'd8) ? int'(v) - 16 : int'(v);
        r  = (sv >>> n) & 15;
      end
      default: begin
        rr = n % 4;
        r  = ((int'(v) >> rr) | (int'(v) << (4 - rr))) & 15;
      end
    endcase
    return r[3:0];
  endfunction

  // Called at a negedge. Issues a request and follows it to its done cycle,
  // checking busy/done every cycle. Returns at the negedge of the done cycle,
  // so an immediate next call exercises back-to-back acceptance in DONE.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [3:0] v,
                       input logic [2:0] n, input bit inject);
    logic [3:0] exp_y;
    exp_y = model(o, v, int'(n));
    start = 1'b1; op = o; a = v; shamt = n;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j <= int'(n); j++) begin
      if (j == 1) begin
        start = 1'b0; a = 4'h0;
      end
      check({tag, " busy"}, busy, (j < int'(n)));
      check({tag, " done"}, done, (j == int'(n)));
      if (j == int'(n)) check({tag, " y"}, y, exp_y);
      if (inject && j == 0 && n != 0) begin
        // Conflicting request while shifting must be ignored.
        start = 1'b1; a = 4'h0; op = ~o; shamt = 3'd0;
      end
      if (j < int'(n)) @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 4'h0; shamt = 3'd0;
    #12;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset y", y, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_op("asr1011x1", 2'b10, 4'b1011, 3'd1, 1'b0); @(negedge clk);
    do_op("asr1000x7", 2'b10, 4'b1000, 3'd7, 1'b0); @(negedge clk);
    do_op("asr0111x2", 2'b10, 4'b0111, 3'd2, 1'b0); @(negedge clk);
    do_op("lsl0011x2", 2'b00, 4'b0011, 3'd2, 1'b0); @(negedge clk);
    do_op("lsr1100x3", 2'b01, 4'b1100, 3'd3, 1'b0); @(negedge clk);
    do_op("ror1001x1", 2'b11, 4'b1001, 3'd1, 1'b0); @(negedge clk);
    do_op("ror1001x5", 2'b11, 4'b1001, 3'd5, 1'b0); @(negedge clk);
    do_op("lsl0101x0", 2'b00, 4'b0101, 3'd0, 1'b0); @(negedge clk);
    check("idle after done", done, 1'b0);
    check("y holds", y, 4'b0101);
    do_op("lsr1111x3 ign", 2'b01, 4'b1111, 3'd3, 1'b1);
    do_op("b2b lsl0001x2", 2'b00, 4'b0001, 3'd2, 1'b0);
    do_op("b2b ror0110x0", 2'b11, 4'b0110, 3'd0, 1'b0);
    @(negedge clk);

    // Reset in the middle of a shift, between clock edges.
    start = 1'b1; op = 2'b01; a = 4'b1010; shamt = 3'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre-abort busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort y", y, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op("post-rst asr1001x1", 2'b10, 4'b1001, 3'd1, 1'b0);
    @(negedge clk);

    // Random operations with random gaps (gap 0 = back-to-back).
    for (int i = 0; i < 40; i++) begin
      logic [1:0] ro;
      logic [3:0] rv;
      logic [2:0] rn;
      logic [3:0] last;
      ro = 2'($urandom_range(3));
      rv = 4'($urandom_range(15));
      rn = 3'($urandom_range(7));
      last = model(ro, rv, int'(rn));
      do_op($sformatf("rnd%0d", i), ro, rv, rn, bit'($urandom_range(1)));
      if ($urandom_range(1) == 1) begin
        @(negedge clk);
        check($sformatf("rnd%0d idle y", i), y, last);
        check($sformatf("rnd%0d idle busy", i), busy, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
